mem_loader: RTL and testbench
=============================

// Module: mem_loader
// PURPOSE
// - Boot/debug loader: turns a framed byte stream (from the UART receiver) into 16-bit word
//   writes on the blkmem-style bus (cyc/stb[1:0]/we/ack); sits directly upstream of blkmem.
// - Bus master only while a frame is in progress; o_hold tells the CPU/arbiter to release the bus.
// PARAMETERS
// - AW     16     memory word-address width; must match the downstream memory's AW
// - SYNC   8'hA5  frame start byte
// PORTS
// - i_clk       in   1   clock; all state changes on posedge
// - i_reset     in   1   asynchronous, active-high reset
// - i_rx_dat    in   8   received byte
// - i_rx_valid  in   1   i_rx_dat valid; byte consumed on a cycle with i_rx_valid && o_rx_ready
// - o_rx_ready  out  1   loader can accept a byte
// - o_addr      out  AW  bus word address
// - o_dat       out  16  bus write data
// - o_we        out  1   write enable; high whenever o_cyc is high
// - o_cyc       out  1   bus cycle
// - o_stb       out  2   byte strobes; always 2'b11 during a cycle
// - i_ack       in   1   bus acknowledge
// - o_hold      out  1   frame in progress: CPU must stay off the bus
// - o_done      out  1   one-cycle pulse: frame finished cleanly
// - o_err       out  1   one-cycle pulse: frame aborted (checksum mismatch, CHECKSUM_EN only)
// BEHAVIOUR
// - Frame, bytes in order: SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, 2*LEN data bytes (hi, lo per word).
//   [CHECKSUM_EN: one checksum byte follows.] ADDR is a word address truncated to AW bits.
//   LEN is a 16-bit word count.
// - States: IDLE -> AH -> AL -> LH -> LL -> DH -> DL -> WR -> (DH | CK | IDLE); CK only with CHECKSUM_EN.
// - IDLE: o_rx_ready=1. Non-SYNC bytes are discarded; SYNC -> AH and o_hold=1 from the next cycle.
// - AH/AL/LH/LL: capture one byte each. After LL: LEN==0 -> CK (if enabled) else IDLE + o_done.
// - DH captures the data high byte; DL captures the low byte -> WR.
// - WR: o_rx_ready=0; o_cyc=o_we=1, o_stb=2'b11, o_addr/o_dat held stable until i_ack.
//   On the i_ack cycle the write completes: o_cyc drops next cycle, addr+=1 (wraps mod 2**AW),
//   remaining-=1; remaining==0 -> CK/IDLE, else DH.
// - Minimum one-cycle bus occupancy per word; zero-wait memory (ack=cyc) gives exactly 1 WR cycle.
// - o_rx_ready=1 in every state except WR; bytes are never dropped during a frame.
// - o_hold=1 from the cycle after SYNC is accepted until the cycle o_done/o_err pulses (inclusive);
//   it deasserts the following cycle.
// - o_done/o_err are registered pulses, one cycle wide, never both high.
// - Reset (any time, including mid-WR): state=IDLE, o_cyc=o_we=0, o_stb=0, o_hold=o_done=o_err=0,
//   o_addr=0, o_dat=0, o_rx_ready=1. A partially written frame is abandoned; words already acked
//   remain in memory.
// - No timeout: a stalled sender leaves o_hold asserted until the frame completes or reset.
// CONFIGURATION
// - CHECKSUM_EN defined: an 8-bit running sum covers every byte after SYNC, including the checksum
//   byte. The frame must sum to 8'h00. CK state: match -> o_done, mismatch -> o_err; both -> IDLE.
//   Data words are still written before the check (no rollback).
// - CHECKSUM_EN undefined: no CK state and no checksum byte; o_err is tied 0.
// TESTING
// - Reset then bytes A5 01 00 00 02 12 34 56 78, ack=cyc -> writes [0x0100]=0x1234, [0x0101]=0x5678;
//   o_done pulses once; o_hold falls.
// - Garbage 00 FF 5A before A5 -> ignored; the frame then loads normally.
// - LEN=0 (A5 00 10 00 00) -> no bus cycle; o_done one cycle after LL.
// - ADDR=0xFFFF, LEN=2, AW=16 -> writes at 0xFFFF then 0x0000.
// - i_ack delayed 3 cycles -> o_cyc/o_addr/o_dat stable 4 cycles; o_rx_ready=0 throughout.
// - CHECKSUM_EN, frame A5 00 00 00 01 AB CD + cksum 0x87 -> o_done; cksum 0x88 -> o_err;
//   word 0xABCD is written in both cases.
// - i_reset asserted mid-WR -> o_cyc=0 immediately (async); a fresh frame then loads correctly.

Source files
------------

// File: rtl/mem_loader.sv
// ----------------------------------------------------------------------------
// mem_loader
//
// Boot/debug loader. It takes a framed byte stream from a UART receiver and
// turns it into 16-bit word writes on a blkmem-style bus. The loader sits
// directly upstream of blkmem. It acts as bus master only while a frame is in
// progress, and o_hold tells the CPU/arbiter to stay off the bus during that
// time.
//
// Frame layout, in byte order:
//   SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, then LEN words sent as (hi, lo) pairs.
//   When CHECKSUM_EN is defined, one checksum byte follows the data.
//   ADDR is a word address truncated to AW bits. LEN is a 16-bit word count.
//
// Optional feature (compile-time macro CHECKSUM_EN):
//   defined   : an 8-bit running sum covers every byte after SYNC, including
//               the checksum byte. A clean frame sums to 8'h00. A mismatch
//               pulses o_err. Data words are written before the check, so a
//               bad frame is not rolled back.
//   undefined : there is no checksum byte and no CK state, and o_err is tied 0.
//
// Parameters:
//   AW    memory word-address width; must match the downstream memory
//   SYNC  frame start byte
//
// Ports:
//   i_clk       clock; all state changes on posedge
//   i_reset     asynchronous, active-high reset
//   i_rx_dat    received byte
//   i_rx_valid  i_rx_dat valid; consumed when i_rx_valid && o_rx_ready
//   o_rx_ready  loader can accept a byte (low only while a write is on the bus)
//   o_addr      bus word address
//   o_dat       bus write data
//   o_we        write enable; high whenever o_cyc is high
//   o_cyc       bus cycle
//   o_stb       byte strobes; 2'b11 during a cycle
//   i_ack       bus acknowledge
//   o_hold      frame in progress; CPU must stay off the bus
//   o_done      one-cycle pulse: frame finished cleanly
//   o_err       one-cycle pulse: frame aborted on checksum mismatch
// ----------------------------------------------------------------------------
module mem_loader #(
  parameter int unsigned AW   = 16,
  parameter logic [7:0]  SYNC = 8'hA5
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [7:0]    i_rx_dat,
  input  logic          i_rx_valid,
  output logic          o_rx_ready,
  output logic [AW-1:0] o_addr,
  output logic [15:0]   o_dat,
  output logic          o_we,
  output logic          o_cyc,
  output logic [1:0]    o_stb,
  input  logic          i_ack,
  output logic          o_hold,
  output logic          o_done,
  output logic          o_err
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_AH   = 4'd1;
  localparam logic [3:0] S_AL   = 4'd2;
  localparam logic [3:0] S_LH   = 4'd3;
  localparam logic [3:0] S_LL   = 4'd4;
  localparam logic [3:0] S_DH   = 4'd5;
  localparam logic [3:0] S_DL   = 4'd6;
  localparam logic [3:0] S_WR   = 4'd7;

  // S_TAIL is where the frame goes after its last word, or straight after LL
  // when LEN==0. TAIL_DONE tells whether that transition is itself the clean
  // end of the frame.
`ifdef CHECKSUM_EN
  localparam logic [3:0] S_CK      = 4'd8;
  localparam logic [3:0] S_TAIL    = S_CK;
  localparam logic       TAIL_DONE = 1'b0;
`else
  localparam logic [3:0] S_TAIL    = S_IDLE;
  localparam logic       TAIL_DONE = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [3:0]    state_q,   state_d;
  logic [AW-1:0] addr_q,    addr_d;
  logic [7:0]    addr_hi_q, addr_hi_d;
  logic [15:0]   len_q,     len_d;
  logic [15:0]   dat_q,     dat_d;
  logic          hold_q,    hold_d;
  logic          done_q,    done_d;
`ifdef CHECKSUM_EN
  logic [7:0]    cks_q,     cks_d;
  logic [7:0]    cks_sum;
  logic          err_q,     err_d;
`endif

  logic          rx_ready;
  logic          rx_take;
  logic [15:0]   len_full;

  // The bus signals decode directly from state_q. Because of this, an
  // asynchronous reset drops o_cyc in the same instant, without waiting for
  // a clock edge.
  assign rx_ready = (state_q != S_WR);
  assign rx_take  = i_rx_valid && rx_ready;
  assign len_full = {len_q[15:8], i_rx_dat};

`ifdef CHECKSUM_EN
  assign cks_sum  = cks_q + i_rx_dat;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // NOTE: every variable gets its default at the top of this block. Any path
  // that skips an assignment then holds the value instead of inferring a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    addr_hi_d = addr_hi_q;
    len_d     = len_q;
    dat_d     = dat_q;
    done_d    = 1'b0;
    hold_d    = hold_q;
`ifdef CHECKSUM_EN
    err_d     = 1'b0;
    // The sum restarts while idle and accumulates every byte taken afterwards.
    if (state_q == S_IDLE) begin
      cks_d = 8'h00;
    end else if (rx_take) begin
      cks_d = cks_sum;
    end else begin
      cks_d = cks_q;
    end
    if (err_q) begin
      hold_d = 1'b0;
    end
`endif
    // o_hold stays high through the cycle of the end pulse, then falls.
    if (done_q) begin
      hold_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        // Any byte other than SYNC is discarded here.
        if (rx_take && (i_rx_dat == SYNC)) begin
          state_d = S_AH;
          hold_d  = 1'b1;
        end
      end

      S_AH: begin
        if (rx_take) begin
          addr_hi_d = i_rx_dat;
          state_d   = S_AL;
        end
      end

      S_AL: begin
        if (rx_take) begin
          addr_d  = AW'({addr_hi_q, i_rx_dat});
          state_d = S_LH;
        end
      end

      S_LH: begin
        if (rx_take) begin
          len_d[15:8] = i_rx_dat;
          state_d     = S_LL;
        end
      end

      S_LL: begin
        if (rx_take) begin
          len_d = len_full;
          if (len_full == 16'd0) begin
            state_d = S_TAIL;
            done_d  = TAIL_DONE;
          end else begin
            state_d = S_DH;
          end
        end
      end

      S_DH: begin
        if (rx_take) begin
          dat_d[15:8] = i_rx_dat;
          state_d     = S_DL;
        end
      end

      S_DL: begin
        if (rx_take) begin
          dat_d[7:0] = i_rx_dat;
          state_d    = S_WR;
        end
      end

      S_WR: begin
        // Address and data stay frozen until the acknowledge arrives. The
        // address then wraps modulo 2**AW.
        if (i_ack) begin
          addr_d = addr_q + AW'(1);
          len_d  = len_q - 16'd1;
          if (len_q == 16'd1) begin
            state_d = S_TAIL;
            done_d  = TAIL_DONE;
          end else begin
            state_d = S_DH;
          end
        end
      end

`ifdef CHECKSUM_EN
      S_CK: begin
        // The checksum byte is included in the sum. A clean frame totals zero.
        if (rx_take) begin
          state_d = S_IDLE;
          if (cks_sum == 8'h00) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then updates from values taken before the edge, whatever order the
  // statements appear in.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      addr_hi_q <= 8'h00;
      len_q     <= 16'h0000;
      dat_q     <= 16'h0000;
      hold_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef CHECKSUM_EN
      cks_q     <= 8'h00;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      addr_hi_q <= addr_hi_d;
      len_q     <= len_d;
      dat_q     <= dat_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
`ifdef CHECKSUM_EN
      cks_q     <= cks_d;
      err_q     <= err_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_rx_ready = rx_ready;
  assign o_cyc      = (state_q == S_WR);
  assign o_we       = o_cyc;
  assign o_stb      = {2{o_cyc}};
  assign o_addr     = addr_q;
  assign o_dat      = dat_q;
  assign o_hold     = hold_q;
  assign o_done     = done_q;
`ifdef CHECKSUM_EN
  assign o_err      = err_q;
`else
  assign o_err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// ----------------------------------------------------------------------------
// tb_mem_loader
//
// Directed bench for mem_loader. Each expected bus write and each expected
// frame outcome is queued when its frame is driven. A negedge monitor pops an
// entry and compares it when the DUT completes a write or pulses done/err.
// The bus slave model acknowledges after ack_delay wait cycles.
// ----------------------------------------------------------------------------
module tb_mem_loader;

  localparam int unsigned AW = 16;

  logic          i_clk;
  logic          i_reset;
  logic [7:0]    i_rx_dat;
  logic          i_rx_valid;
  logic          o_rx_ready;
  logic [AW-1:0] o_addr;
  logic [15:0]   o_dat;
  logic          o_we;
  logic          o_cyc;
  logic [1:0]    o_stb;
  logic          i_ack;
  logic          o_hold;
  logic          o_done;
  logic          o_err;

  mem_loader #(.AW(AW), .SYNC(8'hA5)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rx_dat   (i_rx_dat),
    .i_rx_valid (i_rx_valid),
    .o_rx_ready (o_rx_ready),
    .o_addr     (o_addr),
    .o_dat      (o_dat),
    .o_we       (o_we),
    .o_cyc      (o_cyc),
    .o_stb      (o_stb),
    .i_ack      (i_ack),
    .o_hold     (o_hold),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int vectors     = 0;
  int miscompares = 0;

  // Scoreboards: writes are {addr, data}; outcomes are {done, err}.
  logic [31:0] wq[$];
  logic [1:0]  oq[$];

  localparam logic [1:0] OUT_DONE = 2'b10;
  localparam logic [1:0] OUT_ERR  = 2'b01;

  // Bus slave model: acknowledges after ack_delay wait cycles.
  int ack_delay = 0;
  int wait_cnt  = 0;
  assign i_ack = o_cyc && (wait_cnt == ack_delay);

  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset || !o_cyc || i_ack) wait_cnt <= 0;
    else                            wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor: bus writes, end-of-frame pulses, hold release
  // --------------------------------------------------------------------------
  int   run      = 0;
  logic hold_chk = 1'b0;

  always @(negedge i_clk) begin
    if (i_reset) begin
      run      = 0;
      hold_chk = 1'b0;
    end else begin
      if (o_cyc) begin
        run++;
        check("cyc_we", {31'd0, o_we}, 32'd1);
        check("cyc_stb", {30'd0, o_stb}, 32'd3);
        check("cyc_rx_ready", {31'd0, o_rx_ready}, 32'd0);
        check("cyc_expected", {31'd0, wq.size() != 0}, 32'd1);
        if (wq.size() != 0) begin
          check("wr_addr", {16'd0, o_addr}, {16'd0, wq[0][31:16]});
          check("wr_dat", {16'd0, o_dat}, {16'd0, wq[0][15:0]});
          if (i_ack) begin
            check("wr_cycles", run, ack_delay + 1);
            void'(wq.pop_front());
          end
        end
        if (i_ack) run = 0;
      end else begin
        run = 0;
      end

      if (hold_chk) begin
        check("hold_falls", {31'd0, o_hold}, 32'd0);
        hold_chk = 1'b0;
      end

      if (o_done || o_err) begin
        check("pulse_exclusive", {31'd0, o_done && o_err}, 32'd0);
        check("hold_at_pulse", {31'd0, o_hold}, 32'd1);
        check("pulse_expected", {31'd0, oq.size() != 0}, 32'd1);
        if (oq.size() != 0) begin
          check("frame_outcome", {30'd0, o_done, o_err}, {30'd0, oq.pop_front()});
        end
        hold_chk = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge i_clk);
    i_rx_dat   = b;
    i_rx_valid = 1'b1;
    while (!o_rx_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    check("rx_ready_timeout", {31'd0, o_rx_ready}, 32'd1);
    @(posedge i_clk);
    #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] bs[$]);
    foreach (bs[i]) send_byte(bs[i]);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((wq.size() != 0 || oq.size() != 0 || o_hold) && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    check({tag, "_drained"}, {31'd0, (wq.size() == 0) && (oq.size() == 0) && !o_hold}, 32'd1);
    repeat (2) @(negedge i_clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench timeout");
  end

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    i_reset    = 1'b1;
    i_rx_valid = 1'b0;
    i_rx_dat   = 8'h00;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;

    check("rst_rx_ready", {31'd0, o_rx_ready}, 32'd1);
    check("rst_cyc", {31'd0, o_cyc}, 32'd0);
    check("rst_we", {31'd0, o_we}, 32'd0);
    check("rst_stb", {30'd0, o_stb}, 32'd0);
    check("rst_hold", {31'd0, o_hold}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    check("rst_addr", {16'd0, o_addr}, 32'd0);
    check("rst_dat", {16'd0, o_dat}, 32'd0);

    // Basic two-word frame with a zero-wait memory.
    ack_delay = 0;
    wq.push_back({16'h0100, 16'h1234});
    wq.push_back({16'h0101, 16'h5678});
    oq.push_back(OUT_DONE);
    send_byte(8'hA5);
    check("hold_after_sync", {31'd0, o_hold}, 32'd1);
    send_bytes('{8'h01, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78});
    wait_idle("basic");

    // Garbage ahead of SYNC is discarded.
    send_bytes('{8'h00, 8'hFF, 8'h5A});
    check("garbage_hold", {31'd0, o_hold}, 32'd0);
    check("garbage_cyc", {31'd0, o_cyc}, 32'd0);
    wq.push_back({16'h0200, 16'hBEEF});
    oq.push_back(OUT_DONE);
    send_bytes('{8'hA5, 8'h02, 8'h00, 8'h00, 8'h01, 8'hBE, 8'hEF});
    wait_idle("garbage");

`ifndef CHECKSUM_EN
    // LEN==0: no bus cycle, done right after LL.
    oq.push_back(OUT_DONE);
    send_bytes('{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00});
    check("len0_done", {31'd0, o_done}, 32'd1);
    check("len0_cyc", {31'd0, o_cyc}, 32'd0);
    wait_idle("len0");
`endif

    // Address wraps from the top of memory to zero.
    wq.push_back({16'hFFFF, 16'h1111});
    wq.push_back({16'h0000, 16'h2222});
    oq.push_back(OUT_DONE);
    send_bytes('{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22});
    wait_idle("wrap");

    // Slow acknowledge: the write is held for ack_delay+1 cycles.
    ack_delay = 3;
    wq.push_back({16'h3000, 16'hCAFE});
    oq.push_back(OUT_DONE);
    send_bytes('{8'hA5, 8'h30, 8'h00, 8'h00, 8'h01, 8'hCA, 8'hFE});
    wait_idle("slow_ack");
    ack_delay = 0;

`ifdef CHECKSUM_EN
    // Good checksum, then a bad one; the word is written both times.
    wq.push_back({16'h0000, 16'hABCD});
    oq.push_back(OUT_DONE);
    send_bytes('{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'hAB, 8'hCD, 8'h87});
    wait_idle("cksum_ok");
    wq.push_back({16'h0000, 16'hABCD});
    oq.push_back(OUT_ERR);
    send_bytes('{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01, 8'hAB, 8'hCD, 8'h88});
    wait_idle("cksum_bad");
    // LEN==0 still carries a checksum byte: 00+10+00+00 + F0 = 00.
    oq.push_back(OUT_DONE);
    send_bytes('{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00});
    check("len0_cyc", {31'd0, o_cyc}, 32'd0);
    send_byte(8'hF0);
    check("len0_done", {31'd0, o_done}, 32'd1);
    wait_idle("len0");
`endif

    // Reset in the middle of a write.
    ack_delay = 5;
    wq.push_back({16'h4000, 16'h1122});
    send_bytes('{8'hA5, 8'h40, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22});
    check("midwr_cyc", {31'd0, o_cyc}, 32'd1);
    #2;
    i_reset = 1'b1;
    #1;
    check("midwr_rst_cyc", {31'd0, o_cyc}, 32'd0);
    check("midwr_rst_stb", {30'd0, o_stb}, 32'd0);
    check("midwr_rst_hold", {31'd0, o_hold}, 32'd0);
    check("midwr_rst_ready", {31'd0, o_rx_ready}, 32'd1);
    check("midwr_rst_addr", {16'd0, o_addr}, 32'd0);
    wq.delete();
    ack_delay = 0;
    @(negedge i_clk);
    i_reset = 1'b0;

    wq.push_back({16'h4000, 16'h55AA});
    oq.push_back(OUT_DONE);
`ifdef CHECKSUM_EN
    // 40+00+00+01+55+AA = 0x140 -> 0x40; the check byte is 0xC0.
    send_bytes('{8'hA5, 8'h40, 8'h00, 8'h00, 8'h01, 8'h55, 8'hAA, 8'hC0});
`else
    send_bytes('{8'hA5, 8'h40, 8'h00, 8'h00, 8'h01, 8'h55, 8'hAA});
`endif
    wait_idle("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
